cpu_test_sequencer: RTL and testbench
=====================================

Name: cpu_test_sequencer

Overview:
Synthesisable program-load / run / result-dump sequencer for the single-clock MIPS core.
- Streams a program into instruction memory and releases the CPU clear.
- Waits for the CPU finish flag or a watchdog timeout.
- Reads back a programmable window of data memory as a valid/ready result stream.
- Sits between the bench or host link and the CPU's memory ports, replacing hard-coded memory loading and a fixed three-word dump.

Parameters:
DATA_W, 32, instruction/data word width
IADDR_W, 8, instruction memory word-address width
DADDR_W, 8, data memory word-address width
CNT_W, 8, width of dump_count
CYC_W, 32, width of cycle counter
TIMEOUT_CYC, 4096, RUN-state watchdog limit in cycles; 0 disables watchdog

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse, accepted only in IDLE or DONE
load_valid  in  1  program word valid
load_ready  out  1  sequencer accepts program word
load_data  in  DATA_W  program word
load_last  in  1  marks final program word
imem_we  out  1  instruction memory write enable
imem_addr  out  IADDR_W  instruction memory write address
imem_wdata  out  DATA_W  instruction memory write data
cpu_pcclr  out  1  CPU clear, active-low; 0 holds CPU in reset
cpu_fin  in  1  CPU program-finished flag
dmem_sel  out  1  1 = sequencer owns data memory port
dmem_addr  out  DADDR_W  data memory read address
dmem_rdata  in  DATA_W  data memory read data, combinational
dump_base  in  DADDR_W  first dump address, sampled on start
dump_count  in  CNT_W  words to dump, sampled on start; 0 = no dump
out_valid  out  1  result word valid
out_ready  in  1  consumer accepts result word
out_data  out  DATA_W  result word
out_addr  out  DADDR_W  address of result word
out_last  out  1  final result word
busy  out  1  state is not IDLE or DONE
done  out  1  state is DONE
timeout  out  1  last run ended by watchdog
cycles  out  CYC_W  CPU cycles spent in last RUN

Behaviour:
- Reset (async): state IDLE; every output is 0, including cpu_pcclr=0 (CPU held); internal addresses and counts cleared.
- States: IDLE, LOAD, RUN, DUMP, DONE.
- IDLE/DONE + start: latch dump_base/dump_count; clear imem address, cycles, and timeout; go to LOAD. start in any other state is ignored.
- LOAD: load_ready=1 and cpu_pcclr=0.
  - A transfer occurs when load_valid&load_ready. That cycle: imem_we=1, imem_wdata=load_data, imem_addr=current address. The address increments afterwards, wrapping mod 2^IADDR_W.
  - A transfer with load_last=1 moves to RUN.
  - imem_we is combinational from the handshake; nothing is written without a transfer.
- RUN: cpu_pcclr=1 and cycles increments every cycle, saturating at all-ones.
  - cpu_fin=1 sampled moves to DUMP.
  - Otherwise, if TIMEOUT_CYC!=0 and cycles reaches TIMEOUT_CYC-1, set timeout=1 and move to DUMP.
  - If fin and the timeout limit coincide, fin wins and timeout stays 0.
- DUMP: cpu_pcclr=0 and dmem_sel=1.
  - If the latched count is 0, go straight to DONE with no out_valid.
  - Otherwise: dmem_addr=out_addr=base+index (mod 2^DADDR_W); out_data=dmem_rdata; out_valid=1; out_last=1 when index=count-1.
  - Outputs hold stable while out_ready=0.
  - On out_valid&out_ready, index increments. If it was the last word, go to DONE.
- DONE: done=1; cycles and timeout hold; cpu_pcclr=0. start restarts the sequence.
- Reset asserted mid-operation aborts immediately to IDLE with all outputs 0. Instruction memory contents are not cleared.
- Outputs are registered state or decoded combinationally from state. There is no combinational path from load_valid to load_ready or from out_ready to out_valid.

Test Plan:
1. Reset, start with dump_base=1, dump_count=3; load 4 words with no stalls, the last carrying load_last; CPU stub raises fin after 10 cycles -> imem writes at addresses 0..3; cycles=10; out stream gives addresses 1,2,3 with out_last on 3; done=1; timeout=0.
2. Randomised load_valid gaps and out_ready stalls -> no lost or duplicated words; out_data/out_addr stable during stall; imem_we only on handshake.
3. TIMEOUT_CYC=16, fin never asserted -> RUN exits after 16 cycles; timeout=1; cycles=15; dump still performed.
4. dump_count=0 -> DUMP to DONE in one cycle; out_valid never asserted.
5. dump_base=254, count=4, DADDR_W=8 -> addresses 254,255,0,1.
6. rst pulse during DUMP with out_valid=1 -> all outputs 0 asynchronously; cpu_pcclr=0; a new start runs a complete sequence.

Source files
------------

// File: rtl/cpu_test_sequencer.sv
// Program-load / run / result-dump sequencer for the single-clock MIPS core.
// Loads imem from a stream, runs the CPU under a watchdog, dumps a dmem window.
module cpu_test_sequencer #(
    parameter int DATA_W      = 32,
    parameter int IADDR_W     = 8,
    parameter int DADDR_W     = 8,
    parameter int CNT_W       = 8,
    parameter int CYC_W       = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [DATA_W-1:0]  load_data,
    input  logic               load_last,
    output logic               imem_we,
    output logic [IADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0]  imem_wdata,
    output logic               cpu_pcclr,
    input  logic               cpu_fin,
    output logic               dmem_sel,
    output logic [DADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic [DADDR_W-1:0] dump_base,
    input  logic [CNT_W-1:0]   dump_count,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [DADDR_W-1:0] out_addr,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CYC_W-1:0]   cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_e;

    localparam bit TO_EN = (TIMEOUT_CYC != 0);
    localparam logic [CYC_W-1:0] TO_LIM =
        TO_EN ? CYC_W'(TIMEOUT_CYC - 1) : '0;

    state_e             state_q, state_d;
    logic [IADDR_W-1:0] iaddr_q, iaddr_d;
    logic [DADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CYC_W-1:0]   cycles_q, cycles_d;
    logic               timeout_q, timeout_d;

    logic [DADDR_W-1:0] cur_addr;
    logic               is_last;

    assign cur_addr = base_q + DADDR_W'(idx_q);
    assign is_last  = (idx_q == count_q - CNT_W'(1));
    assign cycles   = cycles_q;
    assign timeout  = timeout_q;

    always_comb begin
        state_d    = state_q;
        iaddr_d    = iaddr_q;
        base_d     = base_q;
        count_d    = count_q;
        idx_d      = idx_q;
        cycles_d   = cycles_q;
        timeout_d  = timeout_q;
        load_ready = 1'b0;
        imem_we    = 1'b0;
        imem_addr  = '0;
        imem_wdata = '0;
        cpu_pcclr  = 1'b0;
        dmem_sel   = 1'b0;
        dmem_addr  = '0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_addr   = '0;
        out_last   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                done = (state_q == S_DONE);
                if (start) begin
                    base_d    = dump_base;
                    count_d   = dump_count;
                    idx_d     = '0;
                    iaddr_d   = '0;
                    cycles_d  = '0;
                    timeout_d = 1'b0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                busy       = 1'b1;
                load_ready = 1'b1;
                imem_addr  = iaddr_q;
                if (load_valid) begin
                    imem_we    = 1'b1;
                    imem_wdata = load_data;
                    iaddr_d    = iaddr_q + IADDR_W'(1);
                    if (load_last) state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy      = 1'b1;
                cpu_pcclr = 1'b1;
                // The exit cycle is not counted, so cycles holds the full RUN cycles before it.
                if (cpu_fin) begin
                    state_d = S_DUMP;
                end else if (TO_EN && cycles_q == TO_LIM) begin
                    timeout_d = 1'b1;
                    state_d   = S_DUMP;
                end else if (cycles_q != '1) begin
                    cycles_d = cycles_q + CYC_W'(1);
                end
            end
            S_DUMP: begin
                busy     = 1'b1;
                dmem_sel = 1'b1;
                if (count_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    dmem_addr = cur_addr;
                    out_addr  = cur_addr;
                    out_data  = dmem_rdata;
                    out_valid = 1'b1;
                    out_last  = is_last;
                    if (out_ready) begin
                        idx_d = idx_q + CNT_W'(1);
                        if (is_last) state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            iaddr_q   <= '0;
            base_q    <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            iaddr_q   <= iaddr_d;
            base_q    <= base_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            cycles_q  <= cycles_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Scoreboard bench for cpu_test_sequencer: directed load/run/dump sequences
// with a CPU finish stub and a combinational data-memory model.
module tb_cpu_test_sequencer;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [DW-1:0] load_data = '0;
    logic          load_last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          cpu_pcclr;
    logic          cpu_fin;
    logic          dmem_sel;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_rdata;
    logic [AW-1:0] dump_base = '0;
    logic [7:0]    dump_count = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [31:0]   cycles;

    cpu_test_sequencer #(
        .DATA_W(32), .IADDR_W(8), .DADDR_W(8),
        .CNT_W(8), .CYC_W(32), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_pcclr(cpu_pcclr), .cpu_fin(cpu_fin),
        .dmem_sel(dmem_sel), .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
        .dump_base(dump_base), .dump_count(dump_count),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
        .busy(busy), .done(done), .timeout(timeout), .cycles(cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } iw_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } ow_t;

    iw_t imem_q[$];
    ow_t out_q[$];

    int checks = 0;
    int failures = 0;

    function automatic logic [DW-1:0] dm(input logic [AW-1:0] a);
        return {16'hC0DE, ~a, a};
    endfunction

    function automatic logic [DW-1:0] pw(input int s, input int i);
        return 32'hA500_0000 + 32'(s * 256 + i);
    endfunction

    assign dmem_rdata = dm(dmem_addr);

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // CPU stub: raises fin once it has been released for fin_after cycles.
    int stub_cnt = 0;
    int fin_after = 0;
    bit fin_en = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) stub_cnt <= 0;
        else if (cpu_pcclr) stub_cnt <= stub_cnt + 1;
        else stub_cnt <= 0;
    end
    assign cpu_fin = fin_en && cpu_pcclr && (stub_cnt >= fin_after);

    bit stall_en = 1'b0;
    bit hold_ready0 = 1'b0;
    always @(posedge clk) begin
        #1;
        if (hold_ready0) out_ready = 1'b0;
        else if (stall_en) out_ready = ($urandom_range(0, 2) != 0);
        else out_ready = 1'b1;
    end

    bit            prev_stall = 1'b0;
    ow_t           held;
    bit            seen_valid = 1'b0;
    int            dsel_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (imem_we) begin
                if (imem_q.size() == 0) begin
                    chk("imem_unexpected_we", 64'(imem_addr), 64'hFFFF);
                end else begin
                    iw_t e;
                    e = imem_q.pop_front();
                    chk("imem_addr", 64'(imem_addr), 64'(e.a));
                    chk("imem_wdata", 64'(imem_wdata), 64'(e.d));
                end
            end
            if (dmem_sel) dsel_cnt++;
            if (out_valid) seen_valid = 1'b1;
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_hold", 64'({out_addr, out_data, out_last}),
                    64'({held.a, held.d, held.l}));
            end
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) begin
                    chk("out_unexpected", 64'(out_addr), 64'hFFFF);
                end else begin
                    ow_t e;
                    e = out_q.pop_front();
                    chk("out_addr", 64'(out_addr), 64'(e.a));
                    chk("out_data", 64'(out_data), 64'(e.d));
                    chk("out_last", 64'(out_last), 64'(e.l));
                end
            end
            prev_stall = out_valid && !out_ready;
            held = '{a: out_addr, d: out_data, l: out_last};
        end
    end

    task automatic start_and_load(input logic [7:0] base, input logic [7:0] cnt,
                                  input int nw, input int seq, input bit gaps);
        seen_valid = 1'b0;
        dsel_cnt = 0;
        for (int j = 0; j < int'(cnt); j++) begin
            logic [AW-1:0] a;
            a = base + AW'(j);
            out_q.push_back('{a: a, d: dm(a), l: (j == int'(cnt) - 1)});
        end
        for (int i = 0; i < nw; i++)
            imem_q.push_back('{a: AW'(i), d: pw(seq, i)});
        dump_base = base;
        dump_count = cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dump_base = '0;
        dump_count = '0;
        for (int i = 0; i < nw; i++) begin
            int n;
            if (gaps) repeat (i % 3) begin @(posedge clk); #1; end
            load_valid = 1'b1;
            load_data = pw(seq, i);
            load_last = (i == nw - 1);
            n = 0;
            forever begin
                @(negedge clk);
                if (load_ready) begin
                    @(posedge clk); #1;
                    break;
                end
                n++;
                if (n > 100) begin
                    chk("load_ready_timeout", 64'(n), 64'd0);
                    break;
                end
            end
            load_valid = 1'b0;
            load_last = 1'b0;
            load_data = '0;
        end
    endtask

    task automatic finish_checks(input logic [31:0] exp_cyc, input bit exp_to);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("done", 64'(done), 64'd1);
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("cycles", 64'(cycles), 64'(exp_cyc));
        chk("timeout", 64'(timeout), 64'(exp_to));
        chk("pcclr_at_done", 64'(cpu_pcclr), 64'd0);
        chk("imem_q_left", 64'(imem_q.size()), 64'd0);
        chk("out_q_left", 64'(out_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_seq(input logic [7:0] base, input logic [7:0] cnt,
                           input int nw, input int seq, input int fa,
                           input bit fe, input bit gaps, input bit stalls,
                           input logic [31:0] exp_cyc, input bit exp_to);
        fin_after = fa;
        fin_en = fe;
        stall_en = stalls;
        start_and_load(base, cnt, nw, seq, gaps);
        finish_checks(exp_cyc, exp_to);
        stall_en = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, 64'({load_ready, imem_we, cpu_pcclr, dmem_sel, out_valid,
                     out_last, busy, done, timeout}), 64'd0);
        chk({nm, "_buses"}, 64'({imem_addr, dmem_addr, out_addr}), 64'd0);
        chk({nm, "_data"}, 64'({imem_wdata, out_data}), 64'd0);
        chk({nm, "_cycles"}, 64'(cycles), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic flow: fin after 10 cycles, dump 1..3.
        run_seq(8'd1, 8'd3, 4, 1, 10, 1'b1, 1'b0, 1'b0, 32'd10, 1'b0);
        // Load gaps and output stalls.
        run_seq(8'd5, 8'd6, 7, 2, 5, 1'b1, 1'b1, 1'b1, 32'd5, 1'b0);
        // Watchdog: no fin, limit 16.
        run_seq(8'h20, 8'd2, 3, 3, 0, 1'b0, 1'b0, 1'b0, 32'd15, 1'b1);
        // Empty dump window.
        run_seq(8'd7, 8'd0, 2, 4, 3, 1'b1, 1'b0, 1'b0, 32'd3, 1'b0);
        chk("empty_dump_cycles", 64'(dsel_cnt), 64'd1);
        chk("empty_dump_no_valid", 64'(seen_valid), 64'd0);
        // Address wrap.
        run_seq(8'd254, 8'd4, 1, 5, 2, 1'b1, 1'b0, 1'b0, 32'd2, 1'b0);

        // Async reset while a result word is pending.
        hold_ready0 = 1'b1;
        fin_after = 3;
        fin_en = 1'b1;
        start_and_load(8'd10, 8'd3, 2, 6, 1'b0);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_all_zero("mid_reset");
        out_q.delete();
        imem_q.delete();
        hold_ready0 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_seq(8'd3, 8'd2, 3, 7, 4, 1'b1, 1'b0, 1'b0, 32'd4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
